// File: rtl/bitmap_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bitmap_pkg
// Description : Shared geometry and bank constants for the 214x160 1 bpp
//               bitmap write path, plus the one-hot bank decode helper.
// Revision    : 1.0 - initial release
// ============================================================================
package bitmap_pkg;

    localparam int WIDTH      = 214;
    localparam int HEIGHT     = 160;
    localparam int BYTES      = WIDTH * HEIGHT / 8;
    localparam int ADDR_W     = 13;
    localparam int BANK_SIZE  = 1024;
    localparam int BANK_COUNT = 5;
    localparam int BANK_BITS  = $clog2(BANK_SIZE);
    localparam int BANK_SEL_W = ADDR_W - BANK_BITS;

    // One-hot select of the RAM bank holding a given upper address slice
    function automatic logic [BANK_COUNT-1:0] bank_onehot(input logic [BANK_SEL_W-1:0] bank_idx);
        logic [BANK_COUNT-1:0] v;
        v = '0;
        for (int b = 0; b < BANK_COUNT; b++) begin
            v[b] = (int'(bank_idx) == b);
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_bitmap_writer_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : sync_edge
// Description : Two-flop synchroniser for an asynchronous input. With
//               EDGE_EN set, a third flop provides rise/fall pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_edge #(
    parameter logic IDLE    = 1'b0,
    parameter bit   EDGE_EN = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;

    // Two-stage synchroniser, reset to the line's idle level
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_meta <= IDLE;
            r_sync <= IDLE;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

    generate
        if (EDGE_EN) begin : g_edge
            logic r_prev;

            // Delayed copy of the synchronised level for edge detection
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_prev <= IDLE;
                end else begin
                    r_prev <= r_sync;
                end
            end

            assign o_rise = r_sync & ~r_prev;
            assign o_fall = ~r_sync & r_prev;
        end else begin : g_no_edge
            assign o_rise = 1'b0;
            assign o_fall = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/spi_bitmap_writer.sv
`default_nettype none
// ============================================================================
// Module      : spi_bitmap_writer
// Description : Receives a 1 bpp frame over SPI (mode 0, MSB first) and
//               emits byte writes into the bitmap RAM banks. Pixel bytes
//               (DC=1) are written at a linear, wrapping address; command
//               bytes (DC=0) rewind the address to 0.
//               Optional macro BITMAP_BANK_SELECT_EN adds registered
//               one-hot bank select and bank-local address outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_bitmap_writer
    import bitmap_pkg::*;
(
    input  logic              Clock,
    input  logic              Reset,
    input  logic              CS_i,
    input  logic              SCK_i,
    input  logic              MOSI_i,
    input  logic              DC_i,
    output logic [ADDR_W-1:0] WrAddr_o,
    output logic [7:0]        WrData_o,
    output logic              WrEnable_o,
    output logic              FrameDone_o
`ifdef BITMAP_BANK_SELECT_EN
    ,
    output logic [BANK_COUNT-1:0] WrBank_o,
    output logic [BANK_BITS-1:0]  WrLocal_o
`endif
);

    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(BYTES - 1);

    logic w_cs, w_sck_rise, w_mosi, w_dc;
    logic w_sck_sync, w_sck_fall;
    logic w_cs_rise, w_cs_fall, w_mosi_rise, w_mosi_fall, w_dc_rise, w_dc_fall;
    logic w_unused_edges;

    logic [2:0]        r_bit_cnt;
    logic [7:0]        r_shift;
    logic [ADDR_W-1:0] r_addr;

    logic [7:0] w_byte;
    logic       w_byte_done;
    logic       w_pixel_done;
    logic       w_last_addr;

    sync_edge #(.IDLE(1'b0), .EDGE_EN(1'b1)) u_sync_sck (
        .clk(Clock), .rst_n(Reset), .i_async(SCK_i),
        .o_sync(w_sck_sync), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
    );
    sync_edge #(.IDLE(1'b1), .EDGE_EN(1'b0)) u_sync_cs (
        .clk(Clock), .rst_n(Reset), .i_async(CS_i),
        .o_sync(w_cs), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );
    sync_edge #(.IDLE(1'b0), .EDGE_EN(1'b0)) u_sync_mosi (
        .clk(Clock), .rst_n(Reset), .i_async(MOSI_i),
        .o_sync(w_mosi), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
    );
    sync_edge #(.IDLE(1'b0), .EDGE_EN(1'b0)) u_sync_dc (
        .clk(Clock), .rst_n(Reset), .i_async(DC_i),
        .o_sync(w_dc), .o_rise(w_dc_rise), .o_fall(w_dc_fall)
    );

    // Only the SCK rising edge and the plain CS/MOSI/DC levels are consumed
    assign w_unused_edges = ^{w_sck_sync, w_sck_fall, w_cs_rise, w_cs_fall,
                              w_mosi_rise, w_mosi_fall, w_dc_rise, w_dc_fall};

    assign w_byte       = {r_shift[6:0], w_mosi};
    assign w_byte_done  = w_sck_rise & ~w_cs & (r_bit_cnt == 3'd7);
    assign w_pixel_done = w_byte_done & w_dc;
    assign w_last_addr  = (r_addr == c_LAST_ADDR);

    // Bit assembly: shift on each SCK rise, discard partial bytes while CS is high
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'd0;
        end else if (w_cs) begin
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'd0;
        end else if (w_sck_rise) begin
            r_shift   <= w_byte;
            r_bit_cnt <= r_bit_cnt + 3'd1;
        end
    end

    // Write strobe, data/address capture and the wrapping address counter
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            WrEnable_o  <= 1'b0;
            FrameDone_o <= 1'b0;
            WrData_o    <= 8'd0;
            WrAddr_o    <= '0;
            r_addr      <= '0;
`ifdef BITMAP_BANK_SELECT_EN
            WrBank_o    <= '0;
            WrLocal_o   <= '0;
`endif
        end else begin
            WrEnable_o  <= w_pixel_done;
            FrameDone_o <= w_pixel_done & w_last_addr;
            if (w_pixel_done) begin
                WrData_o  <= w_byte;
                WrAddr_o  <= r_addr;
`ifdef BITMAP_BANK_SELECT_EN
                WrBank_o  <= bank_onehot(r_addr[ADDR_W-1:BANK_BITS]);
                WrLocal_o <= r_addr[BANK_BITS-1:0];
`else
                // Bank decode is left to external logic on WrAddr_o
`endif
            end
            // A command byte rewinds; otherwise advance once the strobe has been issued
            if (w_byte_done & ~w_dc) begin
                r_addr <= '0;
            end else if (WrEnable_o) begin
                r_addr <= w_last_addr ? '0 : r_addr + ADDR_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_bitmap_writer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_spi_bitmap_writer
// Description : Directed self-checking bench for spi_bitmap_writer.
//               Define BITMAP_BANK_SELECT_EN to include the bank outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_bitmap_writer;

    localparam int N_BYTES = 4280;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        CS_i  = 1'b1;
    logic        SCK_i = 1'b0;
    logic        MOSI_i = 1'b0;
    logic        DC_i  = 1'b1;
    logic [12:0] WrAddr_o;
    logic [7:0]  WrData_o;
    logic        WrEnable_o;
    logic        FrameDone_o;
`ifdef BITMAP_BANK_SELECT_EN
    logic [4:0]  WrBank_o;
    logic [9:0]  WrLocal_o;
`endif

    int tests = 0;
    int failures = 0;

    int          q_addr[$];
    logic [7:0]  q_data[$];
    logic        q_done[$];
`ifdef BITMAP_BANK_SELECT_EN
    logic [4:0]  q_bank[$];
    logic [9:0]  q_local[$];
`endif
    int done_pulses = 0;

    spi_bitmap_writer dut (
        .Clock(Clock), .Reset(Reset), .CS_i(CS_i), .SCK_i(SCK_i),
        .MOSI_i(MOSI_i), .DC_i(DC_i),
        .WrAddr_o(WrAddr_o), .WrData_o(WrData_o),
        .WrEnable_o(WrEnable_o), .FrameDone_o(FrameDone_o)
`ifdef BITMAP_BANK_SELECT_EN
        , .WrBank_o(WrBank_o), .WrLocal_o(WrLocal_o)
`endif
    );

    always #19.86 Clock = ~Clock;

    // Log every write strobe away from the active edge
    always @(negedge Clock) begin
        if (WrEnable_o) begin
            q_addr.push_back(int'(WrAddr_o));
            q_data.push_back(WrData_o);
            q_done.push_back(FrameDone_o);
`ifdef BITMAP_BANK_SELECT_EN
            q_bank.push_back(WrBank_o);
            q_local.push_back(WrLocal_o);
`endif
        end
        if (FrameDone_o) done_pulses++;
    end

    task automatic clear_log();
        q_addr.delete();
        q_data.delete();
        q_done.delete();
`ifdef BITMAP_BANK_SELECT_EN
        q_bank.delete();
        q_local.delete();
`endif
        done_pulses = 0;
    endtask

    // Send the top n bits of b, MSB first, mode 0 (40 ns half-period)
    task automatic spi_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            MOSI_i = b[i];
            #40;
            SCK_i = 1'b1;
            #40;
            SCK_i = 1'b0;
        end
    endtask

    task automatic apply_reset();
        @(negedge Clock);
        Reset = 1'b0;
        repeat (2) @(negedge Clock);
        Reset = 1'b1;
        repeat (4) @(negedge Clock);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge Clock);
        tests++; if (WrEnable_o !== 1'b0) begin failures++; $display("FAIL reset_en got %b want 0", WrEnable_o); end
        tests++; if (WrAddr_o !== 13'd0) begin failures++; $display("FAIL reset_addr got %0d want 0", WrAddr_o); end
        tests++; if (WrData_o !== 8'h00) begin failures++; $display("FAIL reset_data got %h want 00", WrData_o); end
        tests++; if (FrameDone_o !== 1'b0) begin failures++; $display("FAIL reset_done got %b want 0", FrameDone_o); end
        Reset = 1'b1;
        repeat (4) @(negedge Clock);
    endtask

    task automatic test_basic();
        clear_log();
        DC_i = 1'b1;
        CS_i = 1'b0;
        #100;
        spi_bits(8'hFF, 8);
        spi_bits(8'h00, 8);
        #300;
        tests++; if (q_addr.size() !== 2) begin failures++; $display("FAIL basic_count got %0d want 2", q_addr.size()); end
        tests++; if (q_addr[0] !== 0 || q_data[0] !== 8'hFF) begin failures++; $display("FAIL basic_first got addr %0d data %h want addr 0 data FF", q_addr[0], q_data[0]); end
        tests++; if (q_addr[1] !== 1 || q_data[1] !== 8'h00) begin failures++; $display("FAIL basic_second got addr %0d data %h want addr 1 data 00", q_addr[1], q_data[1]); end
        tests++; if (done_pulses !== 0) begin failures++; $display("FAIL basic_done got %0d pulses want 0", done_pulses); end
    endtask

    task automatic test_frame_wrap();
        int bad;
        apply_reset();
        clear_log();
        for (int i = 0; i < N_BYTES; i++) begin
            spi_bits((i % 2 == 0) ? 8'hFF : 8'h00, 8);
        end
        #300;
        tests++; if (q_addr.size() !== N_BYTES) begin failures++; $display("FAIL frame_count got %0d want %0d", q_addr.size(), N_BYTES); end
        tests++; if (done_pulses !== 1) begin failures++; $display("FAIL frame_done_pulses got %0d want 1", done_pulses); end
        bad = 0;
        for (int i = 0; i < q_addr.size(); i++) begin
            if (q_addr[i] !== i || q_data[i] !== ((i % 2 == 0) ? 8'hFF : 8'h00) || q_done[i] !== (i == N_BYTES - 1))
                bad++;
        end
        tests++; if (bad !== 0) begin failures++; $display("FAIL frame_sequence got %0d bad strobes want 0", bad); end
        tests++; if (q_addr[N_BYTES-1] !== 4279 || q_done[N_BYTES-1] !== 1'b1) begin failures++; $display("FAIL frame_last got addr %0d done %b want addr 4279 done 1", q_addr[N_BYTES-1], q_done[N_BYTES-1]); end
`ifdef BITMAP_BANK_SELECT_EN
        tests++; if (q_bank[1024] !== 5'b00010 || q_local[1024] !== 10'd0) begin failures++; $display("FAIL bank_1024 got bank %b local %0d want 00010 0", q_bank[1024], q_local[1024]); end
        tests++; if (q_bank[4279] !== 5'b10000 || q_local[4279] !== 10'd183) begin failures++; $display("FAIL bank_4279 got bank %b local %0d want 10000 183", q_bank[4279], q_local[4279]); end
`endif
        clear_log();
        spi_bits(8'h5A, 8);
        #300;
        tests++; if (q_addr.size() !== 1 || q_addr[0] !== 0 || q_data[0] !== 8'h5A) begin failures++; $display("FAIL wrap_next got n %0d addr %0d data %h want 1 0 5A", q_addr.size(), q_addr[0], q_data[0]); end
        tests++; if (done_pulses !== 0) begin failures++; $display("FAIL wrap_next_done got %0d want 0", done_pulses); end
    endtask

    task automatic test_partial_cs();
        clear_log();
        spi_bits(8'hE7, 5);
        #40;
        CS_i = 1'b1;
        #200;
        CS_i = 1'b0;
        #100;
        spi_bits(8'h3C, 8);
        #300;
        tests++; if (q_addr.size() !== 1) begin failures++; $display("FAIL partial_count got %0d want 1", q_addr.size()); end
        tests++; if (q_addr[0] !== 1 || q_data[0] !== 8'h3C) begin failures++; $display("FAIL partial_byte got addr %0d data %h want addr 1 data 3C", q_addr[0], q_data[0]); end
    endtask

    task automatic test_command();
        apply_reset();
        clear_log();
        for (int i = 0; i < 100; i++) spi_bits(8'h55, 8);
        #300;
        tests++; if (q_addr.size() !== 100 || q_addr[99] !== 99) begin failures++; $display("FAIL cmd_setup got n %0d last %0d want 100 99", q_addr.size(), q_addr[99]); end
        clear_log();
        DC_i = 1'b0;
        #100;
        spi_bits(8'hA5, 8);
        #300;
        tests++; if (q_addr.size() !== 0) begin failures++; $display("FAIL cmd_no_write got %0d strobes want 0", q_addr.size()); end
        DC_i = 1'b1;
        #100;
        spi_bits(8'h81, 8);
        #300;
        tests++; if (q_addr.size() !== 1 || q_addr[0] !== 0 || q_data[0] !== 8'h81) begin failures++; $display("FAIL cmd_rewind got n %0d addr %0d data %h want 1 0 81", q_addr.size(), q_addr[0], q_data[0]); end
    endtask

    task automatic test_reset_mid_byte();
        apply_reset();
        clear_log();
        for (int i = 0; i < 37; i++) spi_bits(8'hC3, 8);
        #300;
        tests++; if (WrAddr_o !== 13'd36 || WrData_o !== 8'hC3) begin failures++; $display("FAIL hold_last got addr %0d data %h want 36 C3", WrAddr_o, WrData_o); end
        spi_bits(8'hF0, 4);
        @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        tests++; if (WrAddr_o !== 13'd0 || WrData_o !== 8'h00 || WrEnable_o !== 1'b0 || FrameDone_o !== 1'b0) begin
            failures++; $display("FAIL midreset_outputs got addr %0d data %h en %b done %b want all 0", WrAddr_o, WrData_o, WrEnable_o, FrameDone_o);
        end
        Reset = 1'b1;
        repeat (4) @(negedge Clock);
        clear_log();
        spi_bits(8'h11, 8);
        #300;
        tests++; if (q_addr.size() !== 1 || q_addr[0] !== 0 || q_data[0] !== 8'h11) begin failures++; $display("FAIL midreset_next got n %0d addr %0d data %h want 1 0 11", q_addr.size(), q_addr[0], q_data[0]); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_frame_wrap();
        test_partial_cs();
        test_command();
        test_reset_mid_byte();
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

    // Bound the whole run
    initial begin
        #3_600_000;
        $display("FAIL watchdog run exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
